fmps_packet_collector: RTL and testbench

- Upstream stage of the FMPS readout streamer.
- Captures FMPS packets arriving from the cell link into a per-index RAM and maintains a presence bitmap.
- Frames each acquisition interval and publishes the status word (bit 31 active, bit 30 valid) that the streamer watches to start its readout sweep.
- Serves the streamer's RAM reads with one clock of latency.

---
 rtl/fmps_packet_collector.sv | 140 ++++++++++++++
 tb/tb_fmps_packet_collector.sv | 243 ++++++++++++++++++++++++
 2 files changed

// File: rtl/fmps_packet_collector.sv
// Purpose: captures FMPS packets into a per-index RAM over one acquisition interval and publishes the status word and presence bitmap.
// Latency: bitmap/counts update 1 clk after rxValid, completion flags 1 clk later; RAM read data 1 clk after address.
// Backpressure: none, rxValid is never stalled; packets outside the interval or mask are dropped. FMPS_COLLECTOR_FIRST_WINS_EN keeps the first payload of duplicates.
module fmps_packet_collector #(
    parameter int INDEX_WIDTH   = 5,
    parameter int TIMEOUT_WIDTH = 20
) (
    input  logic                          sysClk,
    input  logic                          sysReset_n,
    input  logic                          acqStart,
    input  logic [TIMEOUT_WIDTH-1:0]      timeoutCycles,
    input  logic [(1<<INDEX_WIDTH)-1:0]   fmpsEnabledBitmap,
    input  logic [INDEX_WIDTH-1:0]        rxIndex,
    input  logic [31:0]                   rxData,
    input  logic                          rxValid,
    output logic [31:0]                   fmpsCSR,
    output logic [(1<<INDEX_WIDTH)-1:0]   fmpsBitmapAll,
    input  logic [INDEX_WIDTH-1:0]        fmpsReadoutAddress,
    output logic [31:0]                   fmpsReadout
);

    localparam int DEPTH = 1 << INDEX_WIDTH;

    typedef enum logic {
        IDLE   = 1'b0,
        ACTIVE = 1'b1
    } state_t;

    state_t                   state;
    logic                     active;
    logic                     valid;
    logic                     timed_out;
    logic                     restarted;
    logic [7:0]               dup_cnt;
    logic [INDEX_WIDTH:0]     rcv_cnt;
    logic [DEPTH-1:0]         mask;
    logic [TIMEOUT_WIDTH-1:0] timer;
    logic [31:0]              ram [DEPTH];

    logic done_hit;
    logic timeout_hit;
    logic rx_ok;
    logic rx_dup;
    logic rx_new;
    logic ram_we;

    // A packet is only accepted on a plain ACTIVE cycle: not a restart, completion or timeout cycle.
    always_comb begin
        done_hit    = 1'b0;
        timeout_hit = 1'b0;
        rx_ok       = 1'b0;
        rx_dup      = 1'b0;
        rx_new      = 1'b0;
        ram_we      = 1'b0;
        if (state == ACTIVE) begin
            done_hit    = ((fmpsBitmapAll & mask) == mask);
            timeout_hit = !done_hit && (timer == '0);
        end
        rx_ok  = (state == ACTIVE) && !acqStart && !done_hit && !timeout_hit
                 && rxValid && mask[rxIndex];
        rx_dup = rx_ok && fmpsBitmapAll[rxIndex];
        rx_new = rx_ok && !fmpsBitmapAll[rxIndex];
`ifdef FMPS_COLLECTOR_FIRST_WINS_EN
        ram_we = rx_new;
`else
        ram_we = rx_new || rx_dup;
`endif
    end

    always_ff @(posedge sysClk or negedge sysReset_n) begin
        if (!sysReset_n) begin
            state         <= IDLE;
            active        <= 1'b0;
            valid         <= 1'b0;
            timed_out     <= 1'b0;
            restarted     <= 1'b0;
            dup_cnt       <= '0;
            rcv_cnt       <= '0;
            mask          <= '0;
            timer         <= '0;
            fmpsBitmapAll <= '0;
        end else if (acqStart) begin
            state         <= ACTIVE;
            active        <= 1'b1;
            valid         <= 1'b0;
            timed_out     <= 1'b0;
            restarted     <= (state == ACTIVE);
            dup_cnt       <= '0;
            rcv_cnt       <= '0;
            mask          <= fmpsEnabledBitmap;
            timer         <= timeoutCycles;
            fmpsBitmapAll <= '0;
        end else if (state == ACTIVE) begin
            if (done_hit) begin
                state  <= IDLE;
                active <= 1'b0;
                valid  <= 1'b1;
            end else if (timeout_hit) begin
                state     <= IDLE;
                active    <= 1'b0;
                timed_out <= 1'b1;
            end else begin
                timer <= timer - TIMEOUT_WIDTH'(1);
                if (rx_new) begin
                    fmpsBitmapAll[rxIndex] <= 1'b1;
                    rcv_cnt                <= rcv_cnt + (INDEX_WIDTH+1)'(1);
                end
                if (rx_dup && (dup_cnt != 8'hFF)) begin
                    dup_cnt <= dup_cnt + 8'd1;
                end
            end
        end
    end

    // Payload storage is deliberately left uninitialised by reset.
    always_ff @(posedge sysClk) begin
        if (ram_we) begin
            ram[rxIndex] <= rxData;
        end
    end

    always_ff @(posedge sysClk or negedge sysReset_n) begin
        if (!sysReset_n) begin
            fmpsReadout <= '0;
        end else begin
            fmpsReadout <= ram[fmpsReadoutAddress];
        end
    end

    always_comb begin
        fmpsCSR                = '0;
        fmpsCSR[31]            = active;
        fmpsCSR[30]            = valid;
        fmpsCSR[29]            = timed_out;
        fmpsCSR[28]            = restarted;
        fmpsCSR[23:16]         = dup_cnt;
        fmpsCSR[INDEX_WIDTH:0] = rcv_cnt;
    end

endmodule

// File: tb/tb_fmps_packet_collector.sv
// Bench for fmps_packet_collector: per-cycle vector table plus hand sequences for timeout, duplicates, restart and reset.
module tb_fmps_packet_collector;

    localparam int IW = 5;
    localparam int TW = 20;

    logic          sysClk;
    logic          sysReset_n;
    logic          acqStart;
    logic [TW-1:0] timeoutCycles;
    logic [31:0]   fmpsEnabledBitmap;
    logic [IW-1:0] rxIndex;
    logic [31:0]   rxData;
    logic          rxValid;
    logic [31:0]   fmpsCSR;
    logic [31:0]   fmpsBitmapAll;
    logic [IW-1:0] fmpsReadoutAddress;
    logic [31:0]   fmpsReadout;

    fmps_packet_collector #(.INDEX_WIDTH(IW), .TIMEOUT_WIDTH(TW)) dut (
        .sysClk             (sysClk),
        .sysReset_n         (sysReset_n),
        .acqStart           (acqStart),
        .timeoutCycles      (timeoutCycles),
        .fmpsEnabledBitmap  (fmpsEnabledBitmap),
        .rxIndex            (rxIndex),
        .rxData             (rxData),
        .rxValid            (rxValid),
        .fmpsCSR            (fmpsCSR),
        .fmpsBitmapAll      (fmpsBitmapAll),
        .fmpsReadoutAddress (fmpsReadoutAddress),
        .fmpsReadout        (fmpsReadout)
    );

    initial sysClk = 1'b0;
    always #5 sysClk = ~sysClk;

    typedef struct {
        logic          acq;
        logic [31:0]   mask;
        logic [TW-1:0] tmo;
        logic          vld;
        logic [IW-1:0] idx;
        logic [31:0]   dat;
        logic [31:0]   exp_csr;
        logic [31:0]   exp_bm;
    } vec_t;

    localparam int NVEC = 13;
    vec_t vt [NVEC];

    int total;
    int bad;
    logic [31:0] exp_q [$];

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %h want %h", name, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge sysClk);
        #1;
    endtask

    task automatic drive(input logic acq, input logic [31:0] mask, input logic [TW-1:0] tmo,
                         input logic vld, input logic [IW-1:0] idx, input logic [31:0] dat);
        acqStart          = acq;
        fmpsEnabledBitmap = mask;
        timeoutCycles     = tmo;
        rxValid           = vld;
        rxIndex           = idx;
        rxData            = dat;
    endtask

    task automatic idle();
        drive(1'b0, 32'h0, '0, 1'b0, '0, 32'h0);
    endtask

    task automatic rd_push(input logic [IW-1:0] a, input logic [31:0] e);
        fmpsReadoutAddress = a;
        exp_q.push_back(e);
    endtask

    task automatic rd_pop(input string name);
        logic [31:0] e;
        if (exp_q.size() == 0) begin
            total++;
            bad++;
            $display("FAIL %s: scoreboard empty", name);
        end else begin
            e = exp_q.pop_front();
            check(name, fmpsReadout, e);
        end
    endtask

    task automatic rd(input string name, input logic [IW-1:0] a, input logic [31:0] e);
        rd_push(a, e);
        tick();
        rd_pop(name);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1);
    end

    initial begin
        int n;
        logic [31:0] dup_exp;
        total = 0;
        bad   = 0;

        //          acq  mask          tmo     vld  idx    dat           csr            bitmap
        vt[0]  = '{1'b1, 32'h7, 20'd100, 1'b0, 5'd0, 32'h0,  32'h8000_0000, 32'h0};
        vt[1]  = '{1'b0, 32'h0, 20'd0,   1'b1, 5'd0, 32'hA0, 32'h8000_0001, 32'h1};
        vt[2]  = '{1'b0, 32'h0, 20'd0,   1'b1, 5'd1, 32'hA1, 32'h8000_0002, 32'h3};
        vt[3]  = '{1'b0, 32'h0, 20'd0,   1'b1, 5'd2, 32'hA2, 32'h8000_0003, 32'h7};
        vt[4]  = '{1'b0, 32'h0, 20'd0,   1'b0, 5'd0, 32'h0,  32'h4000_0003, 32'h7};
        vt[5]  = '{1'b0, 32'h0, 20'd0,   1'b1, 5'd1, 32'hFF, 32'h4000_0003, 32'h7};
        vt[6]  = '{1'b1, 32'h0, 20'd100, 1'b0, 5'd0, 32'h0,  32'h8000_0000, 32'h0};
        vt[7]  = '{1'b0, 32'h0, 20'd0,   1'b0, 5'd0, 32'h0,  32'h4000_0000, 32'h0};
        vt[8]  = '{1'b1, 32'h1, 20'd0,   1'b0, 5'd0, 32'h0,  32'h8000_0000, 32'h0};
        vt[9]  = '{1'b0, 32'h0, 20'd0,   1'b1, 5'd0, 32'h77, 32'h2000_0000, 32'h0};
        vt[10] = '{1'b1, 32'h1, 20'd1,   1'b0, 5'd0, 32'h0,  32'h8000_0000, 32'h0};
        vt[11] = '{1'b0, 32'h0, 20'd0,   1'b1, 5'd0, 32'hB0, 32'h8000_0001, 32'h1};
        vt[12] = '{1'b0, 32'h0, 20'd0,   1'b0, 5'd0, 32'h0,  32'h4000_0001, 32'h1};

        sysReset_n         = 1'b0;
        fmpsReadoutAddress = '0;
        idle();
        tick();
        tick();
        check("reset_csr", fmpsCSR, 32'h0);
        check("reset_bitmap", fmpsBitmapAll, 32'h0);
        check("reset_readout", fmpsReadout, 32'h0);
        @(negedge sysClk);
        sysReset_n = 1'b1;
        tick();

        for (int i = 0; i < NVEC; i++) begin
            drive(vt[i].acq, vt[i].mask, vt[i].tmo, vt[i].vld, vt[i].idx, vt[i].dat);
            tick();
            check($sformatf("vec%0d_csr", i), fmpsCSR, vt[i].exp_csr);
            check($sformatf("vec%0d_bitmap", i), fmpsBitmapAll, vt[i].exp_bm);
        end
        idle();
        rd("rd_idx1", 5'd1, 32'hA1);
        rd("rd_idx2", 5'd2, 32'hA2);
        rd("rd_idx0", 5'd0, 32'hB0);

        // Timeout: only idx 0 of mask 0x3 arrives.
        drive(1'b1, 32'h3, 20'd10, 1'b0, '0, 32'h0);
        tick();
        idle();
        n = 0;
        while (fmpsCSR[31] === 1'b1 && n < 64) begin
            rxValid = (n == 0);
            rxIndex = 5'd0;
            rxData  = 32'h5A;
            n++;
            tick();
        end
        idle();
        check("timeout_active_cycles", 32'(n), 32'd11);
        check("timeout_csr", fmpsCSR, 32'h2000_0001);
        check("timeout_bitmap", fmpsBitmapAll, 32'h1);

        // Duplicates: idx 1 is never sent so the interval stays open.
        drive(1'b1, 32'h3, 20'd100, 1'b0, '0, 32'h0);
        tick();
        check("dup_start_csr", fmpsCSR, 32'h8000_0000);
        drive(1'b0, 32'h0, '0, 1'b1, 5'd0, 32'h11);
        tick();
        drive(1'b0, 32'h0, '0, 1'b1, 5'd0, 32'h22);
        rd_push(5'd0, 32'h11);
        tick();
        rd_pop("rd_during_write_old");
        drive(1'b0, 32'h0, '0, 1'b1, 5'd5, 32'h55);
        tick();
        idle();
        tick();
        check("dup_csr", fmpsCSR, 32'h8001_0001);
        check("dup_bitmap", fmpsBitmapAll, 32'h1);
`ifdef FMPS_COLLECTOR_FIRST_WINS_EN
        dup_exp = 32'h11;
`else
        dup_exp = 32'h22;
`endif
        rd("dup_ram0", 5'd0, dup_exp);

        // Restart while ACTIVE with a packet on the same cycle.
        drive(1'b1, 32'h3, 20'd5, 1'b1, 5'd1, 32'h99);
        tick();
        idle();
        check("restart_csr", fmpsCSR, 32'h9000_0000);
        check("restart_bitmap", fmpsBitmapAll, 32'h0);
        n = 0;
        while (fmpsCSR[31] === 1'b1 && n < 64) begin
            n++;
            tick();
        end
        check("restart_active_cycles", 32'(n), 32'd6);
        check("restart_end_csr", fmpsCSR, 32'h3000_0000);
        rd("restart_drop_ram1", 5'd1, 32'hA1);

        // Asynchronous reset in the middle of an interval.
        drive(1'b1, 32'h3, 20'd100, 1'b0, '0, 32'h0);
        tick();
        drive(1'b0, 32'h0, '0, 1'b1, 5'd0, 32'hEE);
        tick();
        idle();
        rd("pre_reset_ram0", 5'd0, 32'hEE);
        check("pre_reset_csr", fmpsCSR, 32'h8000_0001);
        #2;
        sysReset_n = 1'b0;
        #1;
        check("async_reset_csr", fmpsCSR, 32'h0);
        check("async_reset_bitmap", fmpsBitmapAll, 32'h0);
        check("async_reset_readout", fmpsReadout, 32'h0);
        @(negedge sysClk);
        sysReset_n = 1'b1;
        drive(1'b0, 32'h0, '0, 1'b1, 5'd1, 32'h12);
        tick();
        tick();
        idle();
        check("post_reset_rx_csr", fmpsCSR, 32'h0);
        check("post_reset_rx_bitmap", fmpsBitmapAll, 32'h0);
        rd("post_reset_ram1", 5'd1, 32'hA1);
        drive(1'b1, 32'h3, 20'd100, 1'b0, '0, 32'h0);
        tick();
        idle();
        check("post_reset_acq_csr", fmpsCSR, 32'h8000_0000);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
